// File: rtl/onehot_codec_pkg.sv
// Shared types and constants for the binary/one-hot codec.
// The result record is sized by the codec's own parameters, so it is declared in the top.
package onehot_codec_pkg;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  localparam int ERR_CNT_W = 16;

  // Packed width of one stored result: mode + one-hot + index + error flag.
  function automatic int result_w(input int one_hot_w, input int bin_w);
    return 1 + one_hot_w + bin_w + 1;
  endfunction

endpackage

// File: rtl/codec_skid_buf.sv
// Two-entry valid/ready skid buffer over an opaque payload.
// Outputs come straight from the main register; in_ready_o is a registered !skid_full.
module codec_skid_buf
  import onehot_codec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_valid_r;
  logic [W-1:0] main_data_r;
  logic         skid_valid_r;
  logic [W-1:0] skid_data_r;
  logic         in_ready_r;

  logic         accept_s;
  logic         emit_s;
  logic         main_valid_s;
  logic [W-1:0] main_data_s;
  logic         skid_valid_s;
  logic [W-1:0] skid_data_s;

  assign accept_s = in_valid_i & in_ready_r;
  assign emit_s   = main_valid_r & out_ready_i;

  // Next-state of both entries; skid is only ever filled while main holds a stalled beat.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    if (emit_s) begin
      if (skid_valid_r) begin
        main_valid_s = 1'b1;
        main_data_s  = skid_data_r;
        skid_valid_s = 1'b0;
      end else if (accept_s) begin
        main_valid_s = 1'b1;
        main_data_s  = in_data_i;
      end else begin
        main_valid_s = 1'b0;
      end
    end else if (accept_s) begin
      if (main_valid_r) begin
        skid_valid_s = 1'b1;
        skid_data_s  = in_data_i;
      end else begin
        main_valid_s = 1'b1;
        main_data_s  = in_data_i;
      end
    end else begin
      main_valid_s = main_valid_r;
    end
  end

  // Storage registers and the registered ready flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {W{1'b0}};
      in_ready_r   <= 1'b1;
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      in_ready_r   <= ~skid_valid_s;
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = main_valid_r;
  assign out_data_o  = main_data_r;

endmodule

// File: rtl/onehot_codec.sv
// Registered, handshaked binary<->one-hot converter with range/legality error flag
// and a saturating count of errored beats that were consumed downstream.
module onehot_codec
  import onehot_codec_pkg::*;
#(
  parameter int ONE_HOT_W = 16,
  parameter int BIN_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 mode_i,
  input  logic [BIN_W-1:0]     bin_i,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 mode_o,
  output logic [ONE_HOT_W-1:0] one_hot_o,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  if ((ONE_HOT_W < 32'sd2) || ((32'sd1 <<< BIN_W) < ONE_HOT_W)) begin : g_param_bad
    $error("onehot_codec: need ONE_HOT_W >= 2 and 2**BIN_W >= ONE_HOT_W");
  end

  typedef struct packed {
    mode_e                mode;
    logic [ONE_HOT_W-1:0] one_hot;
    logic [BIN_W-1:0]     bin;
    logic                 err;
  } result_t;

  localparam int            RES_W    = result_w(ONE_HOT_W, BIN_W);
  localparam logic [BIN_W:0] OH_LIMIT = (BIN_W + 1)'(ONE_HOT_W);
  localparam logic [ONE_HOT_W-1:0] OH_ZERO = {ONE_HOT_W{1'b0}};
  localparam logic [ONE_HOT_W-1:0] OH_ONE  = {{(ONE_HOT_W-1){1'b0}}, 1'b1};

  function automatic logic [ONE_HOT_W-1:0] enc_onehot(input logic [BIN_W-1:0] b);
    logic [ONE_HOT_W-1:0] v;
    v = OH_ZERO;
    for (int i = 0; i < ONE_HOT_W; i++) begin
      v[i] = (b == BIN_W'(i));
    end
    return v;
  endfunction

  // Lowest set bit wins, so multi-hot vectors still report a deterministic index.
  function automatic logic [BIN_W-1:0] dec_index(input logic [ONE_HOT_W-1:0] v);
    logic [BIN_W-1:0] idx;
    idx = {BIN_W{1'b0}};
    for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
      idx = v[i] ? BIN_W'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic onehot_illegal(input logic [ONE_HOT_W-1:0] v);
    return (v == OH_ZERO) || ((v & (v - OH_ONE)) != OH_ZERO);
  endfunction

  mode_e   mode_s;
  result_t result_s;
  result_t out_res_s;
  logic    skid_out_valid_s;
  logic    emit_s;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  assign mode_s = mode_e'(mode_i);

  // Encode/decode the incoming beat; the result is captured at accept time.
  always_comb begin
    result_s.mode    = mode_s;
    result_s.one_hot = one_hot_i;
    result_s.bin     = bin_i;
    result_s.err     = 1'b0;
    case (mode_s)
      MODE_ENC: begin
        result_s.one_hot = enc_onehot(bin_i);
        result_s.err     = ({1'b0, bin_i} >= OH_LIMIT);
      end
      MODE_DEC: begin
        result_s.bin = dec_index(one_hot_i);
        result_s.err = onehot_illegal(one_hot_i);
      end
      default: begin
        result_s.err = 1'b1;
      end
    endcase
  end

  codec_skid_buf #(
    .W(RES_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (result_s),
    .out_valid_o(skid_out_valid_s),
    .out_ready_i(out_ready_i),
    .out_data_o (out_res_s)
  );

  assign emit_s = skid_out_valid_s & out_ready_i;

  // Saturating count of errored beats taken by the consumer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (emit_s && out_res_s.err && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign out_valid_o = skid_out_valid_s;
  assign mode_o      = out_res_s.mode;
  assign one_hot_o   = out_res_s.one_hot;
  assign bin_o       = out_res_s.bin;
  assign err_o       = out_res_s.err;
  assign err_cnt_o   = err_cnt_r;

endmodule

// File: tb/tb_onehot_codec.sv
// Directed bench for onehot_codec: default 16/4 instance plus a 12/4 instance for range errors.
module tb_onehot_codec;
  import onehot_codec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_valid12, mode, out_ready;
  logic [3:0]  bin;
  logic [15:0] one_hot;

  logic        in_ready, out_valid, mode_o_w, err_w;
  logic [15:0] one_hot_w, err_cnt;
  logic [3:0]  bin_w;

  logic        in_ready12, out_valid12, mode12, err12;
  logic [11:0] one_hot12;
  logic [3:0]  bin12;
  logic [15:0] cnt12;

  int errors = 0;
  int checks = 0;

  onehot_codec #(.ONE_HOT_W(16), .BIN_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mode_i(mode), .bin_i(bin), .one_hot_i(one_hot), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .mode_o(mode_o_w), .one_hot_o(one_hot_w),
    .bin_o(bin_w), .err_o(err_w), .err_cnt_o(err_cnt)
  );

  onehot_codec #(.ONE_HOT_W(12), .BIN_W(4)) dut12 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid12), .in_ready_o(in_ready12),
    .mode_i(mode), .bin_i(bin), .one_hot_i(one_hot[11:0]), .out_valid_o(out_valid12),
    .out_ready_i(out_ready), .mode_o(mode12), .one_hot_o(one_hot12),
    .bin_o(bin12), .err_o(err12), .err_cnt_o(cnt12)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic m, input logic [3:0] b, input logic [15:0] oh);
    in_valid = 1'b1; mode = m; bin = b; one_hot = oh;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_valid12 = 1'b0; mode = 1'b0;
    bin = 4'd0; one_hot = 16'h0000; out_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h expected 1", in_ready); end
    checks++; if ({mode_o_w, one_hot_w, bin_w, err_w} !== 22'h0) begin errors++; $display("FAIL reset_fields got %0h expected 0", {mode_o_w, one_hot_w, bin_w, err_w}); end
    checks++; if (err_cnt !== 16'h0000) begin errors++; $display("FAIL reset_err_cnt got %0h expected 0", err_cnt); end
    checks++; if (in_ready12 !== 1'b1 || out_valid12 !== 1'b0) begin errors++; $display("FAIL reset_dut12 got rdy=%0h vld=%0h expected 1/0", in_ready12, out_valid12); end
  endtask

  task automatic test_enc_basic;
    out_ready = 1'b1;
    beat(1'b0, 4'd5, 16'h0000);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL enc5_valid got %0h expected 1", out_valid); end
    checks++; if (one_hot_w !== 16'h0020) begin errors++; $display("FAIL enc5_onehot got %0h expected 0020", one_hot_w); end
    checks++; if (err_w !== 1'b0 || bin_w !== 4'd5 || mode_o_w !== 1'b0) begin errors++; $display("FAIL enc5_fields got err=%0h bin=%0h mode=%0h expected 0/5/0", err_w, bin_w, mode_o_w); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL enc5_drain got %0h expected 0", out_valid); end
  endtask

  task automatic test_dec;
    out_ready = 1'b1;
    beat(1'b1, 4'd0, 16'h0000);
    checks++; if (bin_w !== 4'd0 || err_w !== 1'b1 || mode_o_w !== 1'b1) begin errors++; $display("FAIL dec_zero got bin=%0h err=%0h mode=%0h expected 0/1/1", bin_w, err_w, mode_o_w); end
    beat(1'b1, 4'd0, 16'h0050);
    checks++; if (bin_w !== 4'd4 || err_w !== 1'b1) begin errors++; $display("FAIL dec_multi got bin=%0h err=%0h expected 4/1", bin_w, err_w); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL dec_cnt1 got %0h expected 1", err_cnt); end
    beat(1'b1, 4'd0, 16'h8000);
    checks++; if (bin_w !== 4'd15 || err_w !== 1'b0 || one_hot_w !== 16'h8000) begin errors++; $display("FAIL dec_top got bin=%0h err=%0h oh=%0h expected f/0/8000", bin_w, err_w, one_hot_w); end
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL dec_cnt2 got %0h expected 2", err_cnt); end
    tick;
    checks++; if (err_cnt !== 16'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL dec_final got cnt=%0h vld=%0h expected 2/0", err_cnt, out_valid); end
  endtask

  task automatic test_range12;
    out_ready = 1'b1; mode = 1'b0;
    in_valid12 = 1'b1; bin = 4'd13;
    tick;
    in_valid12 = 1'b0;
    checks++; if (out_valid12 !== 1'b1 || one_hot12 !== 12'h000 || err12 !== 1'b1) begin errors++; $display("FAIL r12_bin13 got vld=%0h oh=%0h err=%0h expected 1/000/1", out_valid12, one_hot12, err12); end
    checks++; if (bin12 !== 4'd13 || mode12 !== 1'b0) begin errors++; $display("FAIL r12_pass got bin=%0h mode=%0h expected d/0", bin12, mode12); end
    tick;
    checks++; if (cnt12 !== 16'd1 || out_valid12 !== 1'b0) begin errors++; $display("FAIL r12_cnt got cnt=%0h vld=%0h expected 1/0", cnt12, out_valid12); end
    in_valid12 = 1'b1; bin = 4'd11;
    tick;
    in_valid12 = 1'b0;
    checks++; if (one_hot12 !== 12'h800 || err12 !== 1'b0) begin errors++; $display("FAIL r12_bin11 got oh=%0h err=%0h expected 800/0", one_hot12, err12); end
    tick;
    checks++; if (cnt12 !== 16'd1) begin errors++; $display("FAIL r12_cnt_hold got %0h expected 1", cnt12); end
  endtask

  task automatic test_back_to_back;
    int  next_in, nout;
    logic acc, emt;
    next_in = 0; nout = 0;
    mode = 1'b0; one_hot = 16'h0000;
    for (int c = 0; c < 60 && nout < 16; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = (next_in < 16);
      bin       = next_in[3:0];
      acc = in_valid && in_ready;
      emt = out_valid && out_ready;
      if (c == 4 || c == 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_hi c=%0d got %0h expected 1", c, in_ready); end
      end
      if (c >= 5 && c <= 7) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_lo c=%0d got %0h expected 0", c, in_ready); end
      end
      if (c >= 4 && c <= 6) begin
        checks++; if (out_valid !== 1'b1 || one_hot_w !== 16'h0008 || bin_w !== 4'd3) begin errors++; $display("FAIL b2b_stall c=%0d got vld=%0h oh=%0h bin=%0h expected 1/0008/3", c, out_valid, one_hot_w, bin_w); end
      end
      if (emt) begin
        checks++; if (one_hot_w !== (16'h0001 << nout) || bin_w !== nout[3:0]) begin errors++; $display("FAIL b2b_order n=%0d got oh=%0h bin=%0h expected %0h/%0h", nout, one_hot_w, bin_w, 16'h0001 << nout, nout[3:0]); end
        nout++;
      end
      if (acc) next_in++;
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (nout != 16 || next_in != 16) begin errors++; $display("FAIL b2b_count got out=%0d in=%0d expected 16/16", nout, next_in); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup k=%0d got %0h expected 0", k, out_valid); end
      tick;
    end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0; mode = 1'b1;
    in_valid = 1'b1; one_hot = 16'h0003;
    tick;
    one_hot = 16'h0000;
    tick;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || err_cnt !== 16'd2) begin errors++; $display("FAIL mid_full got rdy=%0h vld=%0h cnt=%0h expected 0/1/2", in_ready, out_valid, err_cnt); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 16'd0 || err_w !== 1'b0) begin errors++; $display("FAIL mid_reset got vld=%0h rdy=%0h cnt=%0h err=%0h expected 0/1/0/0", out_valid, in_ready, err_cnt, err_w); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale k=%0d got %0h expected 0", k, out_valid); end
    end
    beat(1'b0, 4'd7, 16'h0000);
    checks++; if (out_valid !== 1'b1 || one_hot_w !== 16'h0080 || err_w !== 1'b0) begin errors++; $display("FAIL mid_new got vld=%0h oh=%0h err=%0h expected 1/0080/0", out_valid, one_hot_w, err_w); end
    tick;
  endtask

  task automatic test_saturation;
    rst = 1'b1; tick; rst = 1'b0;
    out_ready = 1'b1; mode = 1'b1; one_hot = 16'h0000;
    in_valid = 1'b1;
    repeat (65534) tick;
    in_valid = 1'b0;
    tick;
    checks++; if (err_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %0h expected fffe", err_cnt); end
    beat(1'b1, 4'd0, 16'h0000);
    tick;
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %0h expected ffff", err_cnt); end
    in_valid = 1'b1;
    tick; tick;
    in_valid = 1'b0;
    tick;
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %0h expected ffff", err_cnt); end
  endtask

  initial begin
    test_reset;
    test_enc_basic;
    test_dec;
    test_range12;
    test_back_to_back;
    test_reset_midstream;
    test_saturation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_codec.md
# onehot_codec

Registered, handshaked, bidirectional binary/one-hot converter with input range and one-hot legality checking. Each beat is tagged with a mode: it either encodes a binary index to a one-hot vector or decodes a one-hot vector to a binary index. The block sits between a producer and a consumer that both use valid/ready. Output is buffered by a 2-entry skid so a full-throughput stream never loses beats under backpressure. It replaces ad-hoc combinational decoders wherever an error flag or a pipelined path is needed.

## Interface
Parameters:
- ONE_HOT_W, 16, width of the one-hot vector; must be ≥2.
- BIN_W, 4, width of the binary index; must satisfy 2**BIN_W ≥ ONE_HOT_W (elaboration-time assertion).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat.
- mode_i  in  1  0 = ENC (bin→one-hot), 1 = DEC (one-hot→bin).
- bin_i  in  BIN_W  binary index; used in ENC.
- one_hot_i  in  ONE_HOT_W  one-hot vector; used in DEC.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  consumer accepts the beat.
- mode_o  out  1  mode of the output beat.
- one_hot_o  out  ONE_HOT_W  ENC result; DEC passes one_hot_i through.
- bin_o  out  BIN_W  DEC result; ENC passes bin_i through.
- err_o  out  1  beat is illegal; see Operation.
- err_cnt_o  out  16  saturating count of errored beats consumed.

## Operation
- Accept: in_valid_i & in_ready_o. Emit: out_valid_o & out_ready_i.
- ENC, bin_i < ONE_HOT_W: one_hot_o = 1 << bin_i, err_o = 0.
- ENC, bin_i ≥ ONE_HOT_W: one_hot_o = 0, err_o = 1.
- DEC, exactly one bit set: bin_o = index of that bit, err_o = 0.
- DEC, zero bits set: bin_o = 0, err_o = 1.
- DEC, more than one bit set: bin_o = index of the lowest set bit, err_o = 1.
- Result is computed at accept and stored with mode_o. Output registers feed nothing back combinationally.
- Storage: main register (drives the outputs) plus a skid register.
  - Accept with main empty, or main being emitted this cycle: result loads main.
  - Accept with main full and not emitted: result loads skid.
  - Emit with skid full: skid moves to main.
- in_ready_o is registered and equals !skid_full. No combinational path from out_ready_i to in_ready_o.
- err_cnt_o increments on each emit with err_o = 1 and saturates at 0xFFFF.

## Timing
- Reset values: out_valid_o 0, in_ready_o 1, mode_o 0, one_hot_o 0, bin_o 0, err_o 0, err_cnt_o 0. Both storage entries are emptied.
- Reset mid-stream drops every held beat; no output follows reset until a new accept.
- Latency: accept in cycle N gives out_valid_o in cycle N+1 when main is free.
- Throughput: 1 beat/cycle while out_ready_i stays high.
- While out_valid_o & !out_ready_i, all output fields are held stable.
- Backpressure: when a beat lands in skid in cycle N, in_ready_o falls in N+1. It rises the cycle after skid drains.
- Accept and emit in the same cycle with main full and skid empty: the new beat goes to main and skid stays empty.
- Beats leave in acceptance order; none are dropped or duplicated.

## Structure
- Package onehot_codec_pkg holds:
  - typedef enum logic {MODE_ENC, MODE_DEC} mode_e;
  - localparam ERR_CNT_W = 16;
  - a parametrised result struct or typedef {mode, one_hot, bin, err} used by both storage entries.
- Sub-module codec_skid_buf: generic 2-entry valid/ready skid buffer over an opaque payload. The top holds the combinational encode/decode, the error counter and one codec_skid_buf instance.

## Test plan
- Reset, then ENC bin_i = 5 with out_ready_i = 1 → one cycle later out_valid_o = 1, one_hot_o = 0x0020, err_o = 0.
- ONE_HOT_W = 12, BIN_W = 4, ENC bin_i = 13 → one_hot_o = 0, err_o = 1; err_cnt_o = 1 after emit.
- DEC one_hot_i = 0x0000 → bin_o = 0, err_o = 1. DEC 0x0050 → bin_o = 4, err_o = 1. DEC 0x8000 → bin_o = 15, err_o = 0.
- Stream ENC 0..15 back-to-back with out_ready_i low for 3 cycles mid-stream:
  - in_ready_o falls exactly one cycle after skid fills.
  - Output order is 0x0001..0x8000 with no loss or duplicates.
  - Output fields stay stable while stalled.
- Pre-load err_cnt_o to 0xFFFE via 2 + 0xFFFC errored beats (or a forced value), then send 3 errored beats → err_cnt_o = 0xFFFF.
- Fill both entries under backpressure, assert rst_i for one cycle → out_valid_o = 0, in_ready_o = 1, err_cnt_o = 0, and no stale beat appears afterwards.
